rob: RTL

- 2-way superscalar reorder buffer, downstream of the rat.
- Receives each dispatched instruction's architectural and physical destination and returns a ROB tag.
- Marks entries complete from the CDB.
- Retires up to 2 instructions per cycle, in order, and drives the rat's retire, retire_dest_idx_in and retire_pdest_idx_in inputs.
- Raises flush when a mispredicted branch retires.

---
 rtl/rob_pkg.sv | 19 +
 rtl/rob.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rob_pkg.sv
// Shared sizing for the reorder buffer and its neighbours.
//   SCALAR  : instructions per cycle (dispatch, complete, retire)
//   ROB_SZ  : number of reorder-buffer entries
//   ROB_IDX : ROB tag width
//   ARF_IDX : architectural register index width
//   PRF_IDX : physical register index width
//   CNT_W   : occupancy counter width (0..ROB_SZ)
package rob_pkg;

    localparam int unsigned SCALAR  = 2;
    localparam int unsigned ROB_SZ  = 32;
    localparam int unsigned ROB_IDX = 5;
    localparam int unsigned ARF_IDX = 5;
    localparam int unsigned PRF_IDX = 6;
    localparam int unsigned CNT_W   = ROB_IDX + 1;

    typedef logic [ROB_IDX-1:0] rob_ptr_t;

endpackage

// File: rtl/rob.sv
// 2-way superscalar reorder buffer.
// Allocates tags for dispatched instructions, records completion from the
// CDB, retires up to two instructions per cycle in order and raises flush
// when a mispredicted branch retires.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   dispatch, dest_idx_in,
//   pdest_idx_in               per-way dispatch valid and destinations
//   cdb_en, cdb_rob_idx,
//   cdb_mispredict             per-lane completion
//   rob_idx_out                tag offered to each dispatch way
//   rob_avail                  free entries, saturated at 2
//   retire, retire_dest_idx_out,
//   retire_pdest_idx_out       per-way retire strobe and destinations to the rat
//   flush                      mispredicted branch retiring this cycle
module rob
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SCALAR-1:0]         dispatch,
    input  logic [SCALAR*ARF_IDX-1:0] dest_idx_in,
    input  logic [SCALAR*PRF_IDX-1:0] pdest_idx_in,
    input  logic [SCALAR-1:0]         cdb_en,
    input  logic [SCALAR*ROB_IDX-1:0] cdb_rob_idx,
    input  logic [SCALAR-1:0]         cdb_mispredict,
    output logic [SCALAR*ROB_IDX-1:0] rob_idx_out,
    output logic [1:0]                rob_avail,
    output logic [SCALAR-1:0]         retire,
    output logic [SCALAR*ARF_IDX-1:0] retire_dest_idx_out,
    output logic [SCALAR*PRF_IDX-1:0] retire_pdest_idx_out,
    output logic                      flush
);

    // Pointer arithmetic wraps naturally at ROB_SZ (a power of two).
    function automatic rob_ptr_t ptr_add(input rob_ptr_t p, input logic [1:0] n);
        return p + ROB_IDX'(n);
    endfunction

    rob_ptr_t          head;
    rob_ptr_t          tail;
    logic [CNT_W-1:0]  count;
    logic [ROB_SZ-1:0] valid;
    logic [ROB_SZ-1:0] complete;
    logic [ROB_SZ-1:0] mispredict;
    logic [ARF_IDX-1:0] dest_mem  [ROB_SZ];
    logic [PRF_IDX-1:0] pdest_mem [ROB_SZ];

    rob_ptr_t          ret_idx   [SCALAR];
    rob_ptr_t          alloc_idx [SCALAR];
    logic [CNT_W-1:0]  free_cnt;
    logic [SCALAR-1:0] accept;
    logic [1:0]        n_alloc;
    logic [1:0]        n_ret;

    // Retire, flush, availability and allocation decode from registered state.
    always_comb begin
        ret_idx[0] = head;
        ret_idx[1] = ptr_add(head, 2'd1);

        retire[0] = valid[ret_idx[0]] & complete[ret_idx[0]];
        // A mispredicted head blocks way1 so only one branch can flush.
        retire[1] = retire[0] & ~mispredict[ret_idx[0]]
                  & valid[ret_idx[1]] & complete[ret_idx[1]];
        flush = (retire[0] & mispredict[ret_idx[0]])
              | (retire[1] & mispredict[ret_idx[1]]);

        retire_dest_idx_out  = '0;
        retire_pdest_idx_out = '0;
        for (int w = 0; w < SCALAR; w++) begin
            if (retire[w]) begin
                retire_dest_idx_out[w*ARF_IDX +: ARF_IDX]  = dest_mem[ret_idx[w]];
                retire_pdest_idx_out[w*PRF_IDX +: PRF_IDX] = pdest_mem[ret_idx[w]];
            end
        end

        // Space freed by this cycle's retires is not offered until next cycle.
        free_cnt  = CNT_W'(ROB_SZ) - count;
        rob_avail = (free_cnt >= CNT_W'(2)) ? 2'd2 : free_cnt[1:0];

        // Active ways are compacted: first active way takes tail.
        alloc_idx[0] = tail;
        alloc_idx[1] = dispatch[0] ? ptr_add(tail, 2'd1) : tail;
        rob_idx_out  = {alloc_idx[1], alloc_idx[0]};

        accept[0] = dispatch[0] & ~flush & (rob_avail != 2'd0);
        accept[1] = dispatch[1] & ~flush
                  & (dispatch[0] ? (rob_avail == 2'd2) : (rob_avail != 2'd0));

        n_alloc = 2'(accept[0]) + 2'(accept[1]);
        n_ret   = 2'(retire[0]) + 2'(retire[1]);
    end

    // Pointers, occupancy and per-entry status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid      <= '0;
            complete   <= '0;
            mispredict <= '0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid      <= '0;
            complete   <= '0;
            mispredict <= '0;
        end else begin
            head  <= ptr_add(head, n_ret);
            tail  <= ptr_add(tail, n_alloc);
            count <= count + CNT_W'(n_alloc) - CNT_W'(n_ret);
            for (int w = 0; w < SCALAR; w++) begin
                if (retire[w]) begin
                    valid[ret_idx[w]] <= 1'b0;
                end
            end
            // Completions to entries that are not in flight are dropped.
            for (int w = 0; w < SCALAR; w++) begin
                if (cdb_en[w] && valid[cdb_rob_idx[w*ROB_IDX +: ROB_IDX]]) begin
                    complete[cdb_rob_idx[w*ROB_IDX +: ROB_IDX]]   <= 1'b1;
                    mispredict[cdb_rob_idx[w*ROB_IDX +: ROB_IDX]] <= cdb_mispredict[w];
                end
            end
            for (int w = 0; w < SCALAR; w++) begin
                if (accept[w]) begin
                    valid[alloc_idx[w]]      <= 1'b1;
                    complete[alloc_idx[w]]   <= 1'b0;
                    mispredict[alloc_idx[w]] <= 1'b0;
                end
            end
        end
    end

    // Destination payload; only read while the entry is valid, so no reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < SCALAR; w++) begin
            if (accept[w]) begin
                dest_mem[alloc_idx[w]]  <= dest_idx_in[w*ARF_IDX +: ARF_IDX];
                pdest_mem[alloc_idx[w]] <= pdest_idx_in[w*PRF_IDX +: PRF_IDX];
            end
        end
    end

endmodule
